shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter: WIDTH, 32, data path width.
REQ-002 Parameter: SHW, 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous and active-low.
REQ-005 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-006 Port: inst31_26  input  6  opcode field.
REQ-007 Port: inst5_0  input  6  funct field.
REQ-008 Port: inst10_6  input  SHW  shamt field, used by SRL and SRA.
REQ-009 Port: dataa  input  WIDTH  rs value; dataa[SHW-1:0] is the shift amount for SRLV and SRAV.
REQ-010 Port: datab  input  WIDTH  rt value; the operand to be shifted.
REQ-011 Port: out0  output  WIDTH  result; held stable from done until the next accepted start.
REQ-012 Port: busy  output  1  high in SHIFT and DONE.
REQ-013 Port: done  output  1  single-cycle completion pulse.
REQ-014 Port: illegal  output  1  high with done when the captured instruction is unsupported; held with out0.

Function
REQ-015 Decode SHALL run only for inst31_26=000000; funct 000010=SRL, 000011=SRA, 000110=SRLV, 000111=SRAV.
REQ-016 Any other opcode or funct SHALL be unsupported.
REQ-017 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-018 IDLE: on start=1, latch datab into the shift register, latch the shift count (inst10_6 or dataa[SHW-1:0]), latch op kind, go to SHIFT.
REQ-019 SHIFT, count != 0: shift register right by one bit; fill the MSB with 0 for SRL/SRLV, or with the current MSB for SRA/SRAV; decrement count.
REQ-020 SHIFT, count == 0: go to DONE; load out0 from the shift register; assert done.
REQ-021 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-022 Latency: with the start edge counted as edge 0, done SHALL be high in the cycle after edge count+1.
REQ-023 Shift count 0 SHALL give done one cycle after acceptance, with out0=datab.
REQ-024 Shift count WIDTH-1 SHALL complete in WIDTH cycles; no modulo or wrap beyond SHW bits.
REQ-025 Unsupported instruction: skip shifting; go to DONE the next cycle with done=1, illegal=1, out0=0.
REQ-026 start during SHIFT or DONE SHALL be ignored; no queuing.
REQ-027 Input changes after acceptance SHALL NOT affect the result in progress.
REQ-028 illegal SHALL clear on the next accepted start.

Reset
REQ-029 When rst_n=0 at a rising edge: state=IDLE; out0=0; busy=0; done=0; illegal=0; count=0.
REQ-030 Reset mid-SHIFT SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-031 Package mips_shift_pkg SHALL hold:
  - the RTYPE opcode constant;
  - the funct constants SRL, SRA, SRLV, SRAV (also used by the left-shift logic);
  - the FSM state enum;
  - the op-kind enum (LOGICAL, ARITH, INVALID).
REQ-032 One combinational sub-module, shr_decode, SHALL map opcode/funct to op kind, variable-amount select and the illegal flag.
REQ-033 Datapath and FSM SHALL reside in shift_right_seq.

Verification
REQ-034 SRL, datab=0x80000000, inst10_6=4, start -> done in the cycle after edge 5, out0=0x08000000, illegal=0.
REQ-035 SRA, datab=0x80000000, inst10_6=4 -> out0=0xF8000000; SRA shamt 31 on 0x80000000 -> 0xFFFFFFFF after 32 cycles.
REQ-036 SRAV, dataa=0x00000023, datab=0xFFFFFFF0 -> shift count 3, out0=0xFFFFFFFE; SRLV on the same values -> 0x1FFFFFFE.
REQ-037 SRL, shamt 0, datab=0x12345678 -> done one cycle after start, out0=0x12345678.
REQ-038 funct 100000 -> done one cycle after start, illegal=1, out0=0; a second start pulse during SHIFT is ignored (exactly one done).
REQ-039 rst_n=0 during a shamt-20 SRL -> no done; out0=0; a subsequent SRL with shamt 1 on 0x2 -> out0=0x1.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// +--------------------------------------------------------------------+
// | mips_shift_pkg                                                     |
// | Shared opcode/funct constants and enums for the MIPS shift blocks. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package mips_shift_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;

    localparam logic [5:0] c_fn_srl  = 6'b000010;
    localparam logic [5:0] c_fn_sra  = 6'b000011;
    localparam logic [5:0] c_fn_srlv = 6'b000110;
    localparam logic [5:0] c_fn_srav = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_LOGICAL = 2'd0,
        OP_ARITH   = 2'd1,
        OP_INVALID = 2'd2
    } op_kind_e;

    // Variable-amount shifts take their count from rs rather than shamt.
    function automatic logic is_var_funct(input logic [5:0] funct);
        return (funct == c_fn_srlv) || (funct == c_fn_srav);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right_seq_if.sv
// +--------------------------------------------------------------------+
// | shift_right_seq_if                                                 |
// | Request/result bundle for the sequential right shifter.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface shift_right_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [5:0]       inst31_26;
    logic [5:0]       inst5_0;
    logic [SHW-1:0]   inst10_6;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [WIDTH-1:0] out0;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, inst31_26, inst5_0, inst10_6, dataa, datab,
        input  out0, busy, done, illegal
    );

    modport slave (
        input  start, inst31_26, inst5_0, inst10_6, dataa, datab,
        output out0, busy, done, illegal
    );
endinterface

`default_nettype wire

// File: rtl/shr_decode.sv
// +--------------------------------------------------------------------+
// | shr_decode                                                         |
// | Maps opcode/funct to right-shift kind, amount source and illegal.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module shr_decode
    import mips_shift_pkg::*;
(
    input  wire logic [5:0] i_opcode,
    input  wire logic [5:0] i_funct,
    output op_kind_e        o_op_kind,
    output logic            o_var_amt,
    output logic            o_illegal
);

    always_comb begin
        o_op_kind = OP_INVALID;
        o_var_amt = 1'b0;
        o_illegal = 1'b1;
        if (i_opcode == c_op_rtype) begin
            case (i_funct)
                c_fn_srl, c_fn_srlv: begin
                    o_op_kind = OP_LOGICAL;
                    o_illegal = 1'b0;
                end
                c_fn_sra, c_fn_srav: begin
                    o_op_kind = OP_ARITH;
                    o_illegal = 1'b0;
                end
                default: ;
            endcase
            o_var_amt = is_var_funct(i_funct);
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_right_seq.sv
// +--------------------------------------------------------------------+
// | shift_right_seq                                                    |
// | Bit-serial SRL/SRA/SRLV/SRAV unit: one bit per clock, done pulse.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_right_seq
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    shift_right_seq_if.slave  bus
);

    op_kind_e         w_op_kind;
    logic             w_var_amt;
    logic             w_illegal;
    logic [SHW-1:0]   w_amt;
    logic             w_fill;
    logic             w_unused_dataa;

    state_e           r_state;
    op_kind_e         r_kind;
    logic [WIDTH-1:0] r_sreg;
    logic [SHW-1:0]   r_count;
    logic [WIDTH-1:0] r_out0;
    logic             r_busy;
    logic             r_done;
    logic             r_illegal;

    shr_decode u_decode (
        .i_opcode  (bus.inst31_26),
        .i_funct   (bus.inst5_0),
        .o_op_kind (w_op_kind),
        .o_var_amt (w_var_amt),
        .o_illegal (w_illegal)
    );

    // Unsupported instructions load a zero count so they fall straight to DONE.
    assign w_amt = w_illegal ? '0 : (w_var_amt ? bus.dataa[SHW-1:0] : bus.inst10_6);
    assign w_fill = (r_kind == OP_ARITH) ? r_sreg[WIDTH-1] : 1'b0;
    assign w_unused_dataa = ^bus.dataa[WIDTH-1:SHW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_kind    <= OP_LOGICAL;
            r_sreg    <= '0;
            r_count   <= '0;
            r_out0    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sreg    <= bus.datab;
                        r_count   <= w_amt;
                        r_kind    <= w_op_kind;
                        r_illegal <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_count != '0) begin
                        r_sreg  <= {w_fill, r_sreg[WIDTH-1:1]};
                        r_count <= r_count - SHW'(1);
                    end else begin
                        r_out0    <= (r_kind == OP_INVALID) ? '0 : r_sreg;
                        r_illegal <= (r_kind == OP_INVALID);
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out0    = r_out0;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// +--------------------------------------------------------------------+
// | tb_shift_right_seq                                                 |
// | Directed plus randomized checks of shift_right_seq against a model.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_shift_right_seq;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_right_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_right_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: what the instruction means, not how the hardware gets there.
    function automatic logic [31:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [4:0] shamt, input logic [31:0] a,
                                          input logic [31:0] b, output int cnt, output bit ill);
        logic signed [31:0] sb;
        int n;
        sb = b;
        if (op != 6'd0 || !(fn == 6'd2 || fn == 6'd3 || fn == 6'd6 || fn == 6'd7)) begin
            ill = 1'b1;
            cnt = 0;
            return 32'd0;
        end
        ill = 1'b0;
        n   = (fn == 6'd6 || fn == 6'd7) ? int'(a % 32) : int'(shamt);
        cnt = n;
        if (fn == 6'd3 || fn == 6'd7) return sb >>> n;
        return b >> n;
    endfunction

    task automatic set_inputs(input logic st, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] shamt, input logic [31:0] a, input logic [31:0] b);
        bus.start     = st;
        bus.inst31_26 = op;
        bus.inst5_0   = fn;
        bus.inst10_6  = shamt;
        bus.dataa     = a;
        bus.datab     = b;
    endtask

    // Called at #1 after a posedge with the DUT idle; returns at #1 after a posedge, idle again.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] shamt, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_out;
        int exp_cnt;
        bit exp_ill;
        int lat;
        exp_out = model(op, fn, shamt, a, b, exp_cnt, exp_ill);
        set_inputs(1'b1, op, fn, shamt, a, b);
        @(posedge clk); #1;
        check({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_accept_illegal_clr"}, 32'(bus.illegal), 32'd0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            // Scramble every input, including start, while the operation runs.
            set_inputs(1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom),
                       5'($urandom), $urandom, $urandom);
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_cnt + 1));
        check({tag, "_out0"}, bus.out0, exp_out);
        check({tag, "_illegal"}, 32'(bus.illegal), 32'(exp_ill));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_hold_out0"}, bus.out0, exp_out);
        check({tag, "_hold_illegal"}, 32'(bus.illegal), 32'(exp_ill));
    endtask

    initial begin
        bit seen_done;
        logic [5:0] fn_tbl [4];
        logic [5:0] op, fn;
        fn_tbl = '{6'd2, 6'd3, 6'd6, 6'd7};

        set_inputs(1'b1, 6'd0, 6'd2, 5'd3, 32'd0, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out0", bus.out0, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", 32'(bus.busy), 32'd0);

        run_op("srl4",     6'd0, 6'd2,  5'd4,  32'd0,        32'h8000_0000);
        run_op("sra4",     6'd0, 6'd3,  5'd4,  32'd0,        32'h8000_0000);
        run_op("sra31",    6'd0, 6'd3,  5'd31, 32'd0,        32'h8000_0000);
        run_op("srav",     6'd0, 6'd7,  5'd0,  32'h0000_0023, 32'hFFFF_FFF0);
        run_op("srlv",     6'd0, 6'd6,  5'd0,  32'h0000_0023, 32'hFFFF_FFF0);
        run_op("srl0",     6'd0, 6'd2,  5'd0,  32'd0,        32'h1234_5678);
        run_op("bad_fn",   6'd0, 6'h20, 5'd9,  32'd5,        32'hDEAD_BEEF);
        run_op("bad_op",   6'd8, 6'd2,  5'd9,  32'd5,        32'hDEAD_BEEF);
        run_op("srlv31",   6'd0, 6'd6,  5'd0,  32'hFFFF_FFFF, 32'hF000_0001);

        // Abort a long shift with reset; no done may follow.
        set_inputs(1'b1, 6'd0, 6'd2, 5'd20, 32'd0, 32'hABCD_1234);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out0", bus.out0, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_op("post_rst", 6'd0, 6'd2, 5'd1, 32'd0, 32'h0000_0002);

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 3)];
            run_op($sformatf("rnd%0d", i), op, fn, 5'($urandom), $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
